// File: rtl/mem_lsu_pkg.sv
// Shared types and helpers for the memory-access stage: memop codes, FSM states,
// and access-size / alignment decoding.
package mem_lsu_pkg;

    typedef enum logic [3:0] {
        MEM_NONE = 4'd0,
        LB       = 4'd1,
        LBU      = 4'd2,
        LH       = 4'd3,
        LHU      = 4'd4,
        LW       = 4'd5,
        LL       = 4'd6,
        SB       = 4'd7,
        SH       = 4'd8,
        SW       = 4'd9,
        SC       = 4'd10
    } memop_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_e;

    localparam logic [31:0] ZeroWord   = 32'h0000_0000;
    localparam logic [4:0]  NOPRegAddr = 5'd0;

    function automatic logic is_load(input memop_e op);
        case (op)
            LB, LBU, LH, LHU, LW, LL: is_load = 1'b1;
            default:                  is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input memop_e op);
        case (op)
            SB, SH, SW, SC: is_store = 1'b1;
            default:        is_store = 1'b0;
        endcase
    endfunction

    // Access size in bytes; 0 for non-memory ops.
    function automatic logic [2:0] op_bytes(input memop_e op);
        case (op)
            LB, LBU, SB:     op_bytes = 3'd1;
            LH, LHU, SH:     op_bytes = 3'd2;
            LW, LL, SW, SC:  op_bytes = 3'd4;
            default:         op_bytes = 3'd0;
        endcase
    endfunction

    function automatic logic misaligned(input memop_e op, input logic [1:0] addr_lo);
        case (op_bytes(op))
            3'd2:    misaligned = addr_lo[0];
            3'd4:    misaligned = (addr_lo != 2'b00);
            default: misaligned = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_if.sv
// Data-bus req/ack interface between the load/store unit (master) and memory (slave).
interface mem_lsu_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32
);
    logic                  mem_req_o;
    logic                  mem_we_o;
    logic [ADDR_W-1:0]     mem_addr_o;
    logic [DATA_W/8-1:0]   mem_sel_o;
    logic [DATA_W-1:0]     mem_wdata_o;
    logic                  mem_ack_i;
    logic [DATA_W-1:0]     mem_rdata_i;

    modport master (
        output mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
        input  mem_ack_i, mem_rdata_i
    );

    modport slave (
        input  mem_req_o, mem_we_o, mem_addr_o, mem_sel_o, mem_wdata_o,
        output mem_ack_i, mem_rdata_i
    );
endinterface

// File: rtl/mem_lsu_lane_fmt.sv
// Combinational lane formatter: store byte enables / replicated data and
// load extraction with sign or zero extension, for either byte order.
module lsu_lane_fmt
    import mem_lsu_pkg::*;
#(
    parameter  int DATA_W     = 32,
    parameter  bit BIG_ENDIAN = 1'b1,
    localparam int LANES      = DATA_W / 8,
    localparam int LANE_W     = $clog2(LANES)
) (
    input  memop_e              memop,
    input  logic [LANE_W-1:0]   lane,
    input  logic [DATA_W-1:0]   st_data,
    input  logic [DATA_W-1:0]   rdata,
    output logic [LANES-1:0]    sel,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   ld_data
);

    int                  nb_s;
    int                  off_s;
    logic [LANES-1:0]    mask_s;
    logic [DATA_W-1:0]   raw_s;

    // Bit offset of the accessed field, byte enables and lane data.
    always_comb begin
        nb_s = int'(op_bytes(memop));
        if (BIG_ENDIAN) begin
            off_s = DATA_W - 32'sd8 * (int'(lane) + nb_s);
        end else begin
            off_s = 32'sd8 * int'(lane);
        end
        // Misaligned combinations are never issued; keep the shift in range.
        if (off_s < 32'sd0) begin
            off_s = 32'sd0;
        end else begin
            off_s = off_s;
        end

        mask_s = LANES'((32'sd1 << nb_s) - 32'sd1);
        sel    = mask_s << (off_s / 32'sd8);
        raw_s  = rdata >> off_s;

        case (nb_s)
            32'sd1:  wdata = {LANES{st_data[7:0]}};
            32'sd2:  wdata = {(LANES/2){st_data[15:0]}};
            32'sd4:  wdata = {(LANES/4){st_data[31:0]}};
            default: wdata = '0;
        endcase

        case (memop)
            LB:      ld_data = DATA_W'($signed(raw_s[7:0]));
            LBU:     ld_data = DATA_W'(raw_s[7:0]);
            LH:      ld_data = DATA_W'($signed(raw_s[15:0]));
            LHU:     ld_data = DATA_W'(raw_s[15:0]);
            LW, LL:  ld_data = DATA_W'($signed(raw_s[31:0]));
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// Memory-access pipeline stage: passes ALU results through, runs load/store
// bus transactions with a pipeline stall, and maintains the LL/SC link bit.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int REG_ADDR_W = 5,
    parameter bit BIG_ENDIAN = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  wd_i,
    input  logic                   wreg_i,
    input  logic [DATA_W-1:0]      wdata_i,
    input  memop_e                 memop_i,
    input  logic [ADDR_W-1:0]      mem_addr_i,
    input  logic [DATA_W-1:0]      st_data_i,
    input  logic                   llbit_clr_i,
    output logic [REG_ADDR_W-1:0]  wd_o,
    output logic                   wreg_o,
    output logic [DATA_W-1:0]      wdata_o,
    output logic                   stallreq_o,
    output logic                   misalign_o,
    mem_lsu_if.master              bus
);

    localparam int LANES  = DATA_W / 8;
    localparam int LANE_W = $clog2(LANES);

    lsu_state_e          state_r, state_s;
    logic                llbit_r, llbit_s;
    logic [DATA_W-1:0]   ld_data_r, ld_data_s;

    logic                req_s, stall_s, misal_s, wreg_s, ack_s, req_out_s;
    logic [DATA_W-1:0]   wdata_s;
    logic                bad_align_s, sc_fail_s, mem_op_s;
    logic [LANES-1:0]    fmt_sel_s;
    logic [DATA_W-1:0]   fmt_wdata_s, fmt_ld_s;

    lsu_lane_fmt #(
        .DATA_W     (DATA_W),
        .BIG_ENDIAN (BIG_ENDIAN)
    ) u_fmt (
        .memop   (memop_i),
        .lane    (mem_addr_i[LANE_W-1:0]),
        .st_data (st_data_i),
        .rdata   (bus.mem_rdata_i),
        .sel     (fmt_sel_s),
        .wdata   (fmt_wdata_s),
        .ld_data (fmt_ld_s)
    );

    assign mem_op_s    = (memop_i != MEM_NONE);
    assign bad_align_s = misaligned(memop_i, mem_addr_i[1:0]);
    assign sc_fail_s   = (memop_i == SC) && !llbit_r;

    // FSM state, link bit and captured load data.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            llbit_r   <= 1'b0;
            ld_data_r <= '0;
        end else begin
            state_r   <= state_s;
            llbit_r   <= llbit_s;
            ld_data_r <= ld_data_s;
        end
    end

    // Next state, stall/request control and write-back selection.
    always_comb begin
        state_s = state_r;
        req_s   = 1'b0;
        stall_s = 1'b0;
        misal_s = 1'b0;
        wreg_s  = wreg_i;
        wdata_s = wdata_i;
        case (state_r)
            IDLE: begin
                if (!mem_op_s) begin
                    state_s = IDLE;
                end else if (bad_align_s) begin
                    misal_s = 1'b1;
                    wreg_s  = 1'b0;
                end else if (sc_fail_s) begin
                    wdata_s = '0;
                end else begin
                    req_s   = 1'b1;
                    stall_s = 1'b1;
                    wreg_s  = 1'b0;
                    if (bus.mem_ack_i) begin
                        state_s = DONE;
                    end else begin
                        state_s = BUSY;
                    end
                end
            end
            BUSY: begin
                req_s   = 1'b1;
                stall_s = 1'b1;
                wreg_s  = 1'b0;
                if (bus.mem_ack_i) begin
                    state_s = DONE;
                end else begin
                    state_s = BUSY;
                end
            end
            DONE: begin
                // Only a successful SC can reach DONE, so its result is always 1.
                if (is_load(memop_i)) begin
                    wdata_s = ld_data_r;
                end else if (memop_i == SC) begin
                    wdata_s = DATA_W'(1'b1);
                end else begin
                    wdata_s = wdata_i;
                end
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        ack_s = req_s && bus.mem_ack_i;
        if (ack_s) begin
            ld_data_s = fmt_ld_s;
        end else begin
            ld_data_s = ld_data_r;
        end

        if (llbit_clr_i) begin
            llbit_s = 1'b0;
        end else if (ack_s && (memop_i == LL)) begin
            llbit_s = 1'b1;
        end else if (ack_s && (memop_i == SC)) begin
            llbit_s = 1'b0;
        end else begin
            llbit_s = llbit_r;
        end
    end

    // Everything is forced low while reset is asserted, including the pass-through path.
    assign req_out_s       = rst & req_s;
    assign wd_o            = rst ? wd_i : REG_ADDR_W'(NOPRegAddr);
    assign wreg_o          = rst & wreg_s;
    assign wdata_o         = rst ? wdata_s : DATA_W'(ZeroWord);
    assign stallreq_o      = rst & stall_s;
    assign misalign_o      = rst & misal_s;

    assign bus.mem_req_o   = req_out_s;
    assign bus.mem_we_o    = req_out_s & is_store(memop_i);
    assign bus.mem_addr_o  = req_out_s ? {mem_addr_i[ADDR_W-1:LANE_W], {LANE_W{1'b0}}} : '0;
    assign bus.mem_sel_o   = req_out_s ? fmt_sel_s : '0;
    assign bus.mem_wdata_o = (req_out_s && is_store(memop_i)) ? fmt_wdata_s : '0;

endmodule
